// File: rtl/hub75_capture_pkg.sv
// Shared definitions for the HUB75 sink-side capture block.
// Holds the RGB pin-group type, default geometry, the row-address width,
// the panel line indices used by the synchronizer bank, and the FSM encoding.
package hub75_capture_pkg;

  localparam int COLS_DEF  = 64;
  localparam int CNT_W_DEF = 8;
  localparam int ADDR_W    = 4;

  // One pixel as it appears on a colour pin group; packs to {R,G,B}.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } hub75_rgb_t;

  // Bit positions of each panel line inside the synchronizer bank.
  localparam int L_B1   = 0;
  localparam int L_G1   = 1;
  localparam int L_R1   = 2;
  localparam int L_B0   = 3;
  localparam int L_G0   = 4;
  localparam int L_R0   = 5;
  localparam int L_A    = 6;
  localparam int L_B    = 7;
  localparam int L_C    = 8;
  localparam int L_D    = 9;
  localparam int L_OE   = 10;
  localparam int L_LAT  = 11;
  localparam int L_HCLK = 12;
  localparam int NLINES = 13;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/hub75_capture_if.sv
// Row-delivery bus between the HUB75 capture block and its consumer.
// master: capture side (drives the row image and status, samples row_ready).
// slave : consumer side (drives row_ready, samples everything else).
interface hub75_capture_if #(
  parameter int COLS  = hub75_capture_pkg::COLS_DEF,
  parameter int CNT_W = hub75_capture_pkg::CNT_W_DEF
) ();

  logic                 row_valid;
  logic                 row_ready;
  logic [3:0]           row_addr;
  logic [3*COLS-1:0]    row_top;
  logic [3*COLS-1:0]    row_bot;
  logic                 row_len_err;
  logic [CNT_W-1:0]     oe_on_cycles;
  logic                 frame_start;
  logic                 overrun;

  modport master (
    output row_valid, row_addr, row_top, row_bot, row_len_err,
           oe_on_cycles, frame_start, overrun,
    input  row_ready
  );

  modport slave (
    input  row_valid, row_addr, row_top, row_bot, row_len_err,
           oe_on_cycles, frame_start, overrun,
    output row_ready
  );

endinterface

// File: rtl/hub75_sync_edge.sv
// Two-flop synchronizer for one asynchronous panel line plus a third flop
// for rising-edge detection.
// Ports: clk, rst (async, active-high), d (raw line),
//        q (synchronized level, stage 2), rise (one-cycle rising-edge pulse
//        aligned with q).
module hub75_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      // p0/p1: metastability guard; p2: previous level for edge detect
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign q    = sync_p1;
  assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 panel sink: oversamples the panel lines in the clk domain, rebuilds
// each latched row pair into two 3*COLS-bit images (column c at bits
// [3c+2:3c] = {R,G,B}, first-shifted pixel ends at column COLS-1) and offers
// them on a valid/ready bus together with address, length error, OE-on time,
// frame-start pulse and a sticky overrun flag.
// Ports: clk, rst (async, active-high), hub_clk, A-D, R0/G0/B0, R1/G1/B1,
//        LAT, OE (raw panel lines), row_if (master side of the row bus).
module hub75_capture import hub75_capture_pkg::*; #(
  parameter int COLS  = COLS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic hub_clk,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic R0,
  input  logic G0,
  input  logic B0,
  input  logic R1,
  input  logic G1,
  input  logic B1,
  input  logic LAT,
  input  logic OE,
  hub75_capture_if.master row_if
);

  localparam int W = 3 * COLS;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NLINES-1:0] lines_raw, lines_s, lines_rise;
  logic              unused_rise;

  assign lines_raw = {hub_clk, LAT, OE, D, C, B, A, R0, G0, B0, R1, G1, B1};

  for (genvar i = 0; i < NLINES; i++) begin : g_sync
    hub75_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (lines_raw[i]),
      .q    (lines_s[i]),
      .rise (lines_rise[i])
    );
  end

  // Only the shift clock and latch need edges; the other lines are levels.
  assign unused_rise = ^lines_rise[L_OE:0];

  logic                hub_rise, lat_rise, oe_s, accept;
  logic [ADDR_W-1:0]   addr_s;
  hub75_rgb_t          top_px, bot_px;

  assign hub_rise = lines_rise[L_HCLK];
  assign lat_rise = lines_rise[L_LAT];
  assign oe_s     = lines_s[L_OE];
  assign addr_s   = {lines_s[L_D], lines_s[L_C], lines_s[L_B], lines_s[L_A]};
  assign top_px   = '{r: lines_s[L_R0], g: lines_s[L_G0], b: lines_s[L_B0]};
  assign bot_px   = '{r: lines_s[L_R1], g: lines_s[L_G1], b: lines_s[L_B1]};
  assign accept   = !row_if.row_valid || row_if.row_ready;

  logic [W-1:0]     top_sr, bot_sr, top_nxt, bot_nxt;
  logic [CNT_W-1:0] shift_cnt, cnt_nxt, oe_cnt;
  logic [0:0]       state;

  // Shift is folded in ahead of the commit so a coincident edge pair
  // commits the row including that final pixel.
  always_comb begin
    top_nxt = top_sr;
    bot_nxt = bot_sr;
    cnt_nxt = shift_cnt;
    if (hub_rise) begin
      top_nxt = {top_sr[W-4:0], top_px};
      bot_nxt = {bot_sr[W-4:0], bot_px};
      cnt_nxt = sat_inc(shift_cnt);
    end
  end

  // Row assembly stage: shift registers, counters, FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_sr    <= '0;
      bot_sr    <= '0;
      shift_cnt <= '0;
      oe_cnt    <= '0;
      state     <= ST_IDLE;
    end else begin
      top_sr    <= top_nxt;
      bot_sr    <= bot_nxt;
      shift_cnt <= lat_rise ? '0 : cnt_nxt;
      if (lat_rise)
        oe_cnt <= '0;
      else if (!oe_s)
        oe_cnt <= sat_inc(oe_cnt);
      case (state)
        ST_IDLE:  if (!lat_rise && hub_rise) state <= ST_SHIFT;
        ST_SHIFT: if (lat_rise) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Output stage: commit, handshake, status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_if.row_valid    <= 1'b0;
      row_if.row_addr     <= '0;
      row_if.row_top      <= '0;
      row_if.row_bot      <= '0;
      row_if.row_len_err  <= 1'b0;
      row_if.oe_on_cycles <= '0;
      row_if.frame_start  <= 1'b0;
      row_if.overrun      <= 1'b0;
    end else begin
      row_if.frame_start <= 1'b0;
      if (lat_rise) begin
        if (accept) begin
          row_if.row_valid    <= 1'b1;
          row_if.row_addr     <= addr_s;
          row_if.row_top      <= top_nxt;
          row_if.row_bot      <= bot_nxt;
          row_if.row_len_err  <= (cnt_nxt != CNT_W'(COLS));
          row_if.oe_on_cycles <= oe_cnt;
          row_if.frame_start  <= (addr_s == '0);
        end else begin
          row_if.overrun <= 1'b1;
        end
      end else if (row_if.row_valid && row_if.row_ready) begin
        row_if.row_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hub75_capture.sv
// Scoreboard bench for hub75_capture: a behavioural panel model pushes the
// expected row when each latch is driven; a negedge monitor pops and
// compares whenever the DUT transfers a row.
module tb_hub75_capture;
  import hub75_capture_pkg::*;

  localparam int COLS  = 64;
  localparam int CNT_W = 8;
  localparam int W     = 3 * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hub_clk = 1'b0, LAT = 1'b0, OE = 1'b1;
  logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic R0 = 1'b0, G0 = 1'b0, B0 = 1'b0, R1 = 1'b0, G1 = 1'b0, B1 = 1'b0;

  hub75_capture_if #(.COLS(COLS), .CNT_W(CNT_W)) row_if ();

  hub75_capture #(.COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hub_clk(hub_clk),
    .A(A), .B(B), .C(C), .D(D),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .LAT(LAT), .OE(OE), .row_if(row_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       addr;
    logic [W-1:0]     top;
    logic [W-1:0]     bot;
    logic             len_err;
    logic [CNT_W-1:0] oe;
    logic             oe_chk;
  } exp_t;

  exp_t sb[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int fs_cnt  = 0;

  logic [W-1:0] top_m = '0, bot_m = '0;
  int           cnt_m = 0;
  int           oe_exp_m = 0;
  bit           first_after_rst = 1'b1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_px(input logic [2:0] t, input logic [2:0] b);
    {R0, G0, B0} = t;
    {R1, G1, B1} = b;
    cyc(1);
    hub_clk = 1'b1;
    cyc(4);
    hub_clk = 1'b0;
    cyc(3);
    top_m = {top_m[W-4:0], t};
    bot_m = {bot_m[W-4:0], b};
    if (cnt_m < 255) cnt_m++;
  endtask

  task automatic shift_rand(input int n);
    for (int i = 0; i < n; i++)
      shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  task automatic latch(input logic [3:0] addr, input bit push);
    exp_t e;
    e.addr    = addr;
    e.top     = top_m;
    e.bot     = bot_m;
    e.len_err = (cnt_m != COLS);
    e.oe      = CNT_W'(oe_exp_m);
    e.oe_chk  = !first_after_rst;
    if (push) sb.push_back(e);
    first_after_rst = 1'b0;
    cnt_m    = 0;
    oe_exp_m = 0;
    {D, C, B, A} = addr;
    cyc(2);
    LAT = 1'b1;
    cyc(4);
    LAT = 1'b0;
    cyc(4);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!row_if.row_valid && n < 50) begin
      cyc(1);
      n++;
    end
    chk("valid_timeout", row_if.row_valid, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      cyc(1);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && row_if.row_valid && row_if.row_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_row", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("row_addr", row_if.row_addr, e.addr);
        chk("row_top", row_if.row_top, e.top);
        chk("row_bot", row_if.row_bot, e.bot);
        chk("row_len_err", row_if.row_len_err, e.len_err);
        if (e.oe_chk) chk("oe_on_cycles", row_if.oe_on_cycles, e.oe);
      end
    end
    if (!rst && row_if.frame_start) begin
      fs_cnt++;
      chk("fs_addr", row_if.row_addr, 4'd0);
      chk("fs_valid", row_if.row_valid, 1'b1);
    end
  end

  initial begin
    int fs0;
    bit spur;
    logic [W-1:0] t2;
    row_if.row_ready = 1'b0;
    cyc(3);
    chk("rst_valid", row_if.row_valid, 1'b0);
    chk("rst_top", row_if.row_top, '0);
    chk("rst_overrun", row_if.overrun, 1'b0);
    rst = 1'b0;
    cyc(3);

    // 1: red top, blue bottom, addr 5
    for (int i = 0; i < COLS; i++) shift_px(3'b100, 3'b001);
    latch(4'd5, 1'b1);
    wait_valid();
    chk("t1_addr", row_if.row_addr, 4'd5);
    chk("t1_top", row_if.row_top, {COLS{3'b100}});
    chk("t1_bot", row_if.row_bot, {COLS{3'b001}});
    chk("t1_len_err", row_if.row_len_err, 1'b0);
    row_if.row_ready = 1'b1;
    drain("t1_drain");
    row_if.row_ready = 1'b0;

    // 2: first pixel green, rest black
    shift_px(3'b010, 3'b000);
    for (int i = 1; i < COLS; i++) shift_px(3'b000, 3'b000);
    latch(4'd2, 1'b1);
    wait_valid();
    t2 = '0;
    t2[W-1 -: 3] = 3'b010;
    chk("t2_top", row_if.row_top, t2);
    chk("t2_bot", row_if.row_bot, '0);
    row_if.row_ready = 1'b1;
    drain("t2_drain");

    // 3: short and long rows
    shift_rand(63);
    latch(4'd6, 1'b1);
    shift_rand(70);
    latch(4'd7, 1'b1);
    drain("t3_drain");

    // 4: overrun with consumer stalled
    row_if.row_ready = 1'b0;
    shift_rand(COLS);
    latch(4'd3, 1'b1);
    wait_valid();
    shift_rand(COLS);
    latch(4'd4, 1'b0);
    chk("t4_overrun", row_if.overrun, 1'b1);
    chk("t4_held_addr", row_if.row_addr, 4'd3);
    chk("t4_held_top", row_if.row_top, sb[0].top);
    row_if.row_ready = 1'b1;
    drain("t4_drain");
    cyc(2);
    chk("t4_valid_clr", row_if.row_valid, 1'b0);

    // 5: frame start on address 0 only
    fs0 = fs_cnt;
    latch(4'd15, 1'b1);
    latch(4'd0, 1'b1);
    drain("t5_drain");
    cyc(4);
    chk("t5_fs_count", fs_cnt - fs0, 1);

    // 6: OE-on time, saturation, then reset mid-shift
    cyc(5);
    OE = 1'b0;
    cyc(100);
    OE = 1'b1;
    cyc(5);
    shift_rand(COLS);
    oe_exp_m = 100;
    latch(4'd8, 1'b1);
    drain("t6_drain_oe");
    OE = 1'b0;
    cyc(300);
    OE = 1'b1;
    cyc(5);
    oe_exp_m = 255;
    latch(4'd10, 1'b1);
    drain("t6_drain_sat");

    row_if.row_ready = 1'b0;
    shift_rand(COLS);
    latch(4'd11, 1'b1);
    wait_valid();
    latch(4'd12, 1'b0);
    shift_rand(10);
    hub_clk = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("r_valid", row_if.row_valid, 1'b0);
    chk("r_top", row_if.row_top, '0);
    chk("r_bot", row_if.row_bot, '0);
    chk("r_addr", row_if.row_addr, 4'd0);
    chk("r_overrun", row_if.overrun, 1'b0);
    chk("r_fs", row_if.frame_start, 1'b0);
    sb.delete();
    top_m = '0;
    bot_m = '0;
    cnt_m = 0;
    first_after_rst = 1'b1;
    hub_clk = 1'b0;
    cyc(3);
    rst = 1'b0;
    spur = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (row_if.row_valid) spur = 1'b1;
    end
    chk("r_no_spurious", spur, 1'b0);
    row_if.row_ready = 1'b1;
    shift_rand(COLS);
    latch(4'd9, 1'b1);
    drain("r_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
